bus_responder_8088: RTL and testbench
=====================================

BUS_RESPONDER_8088 -- requirements
Module: bus_responder_8088

Interface
REQ-001 Parameter BASE_ADDR, default 20'h00000, decode base compared against masked latched address.
REQ-002 Parameter ADDR_MASK, default 20'hF0000, bits of address participating in decode.
REQ-003 Parameter IOM_SEL, default 1'b0, iom value claimed (0 memory, 1 I/O).
REQ-004 Parameter WAIT_CYCLES, default 2, extra ready-low cycles after mem_ack (range 0-15).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 a  input  20  bus address, valid in cycle ale=1.
REQ-008 ale  input  1  address latch enable from master.
REQ-009 iom  input  1  memory/I/O select (1 = I/O).
REQ-010 rd_n, wr_n, den_n  input  1 each  active-low read, write, data-enable strobes.
REQ-011 ad_i  input  8  data from bus (write data).
REQ-012 ad_o  output  8  data to bus; ad_oe  output  1  bus drive enable.
REQ-013 ready  output  1  high = responder not stalling the cycle.
REQ-014 mem_addr  output  20; mem_wdata  output  8; mem_re, mem_we  output  1  single-cycle strobes to backing store.
REQ-015 mem_rdata  input  8; mem_ack  input  1  backing-store completion, earliest one cycle after strobe.

Function
REQ-016 States SHALL be IDLE, ADDR, RD_WAIT, RD_DATA, WR_WAIT, END, DRAIN.
REQ-017 Any state except RD_WAIT/WR_WAIT/DRAIN with ale=1 SHALL latch a into mem_addr, latch sel=((a&ADDR_MASK)==(BASE_ADDR&ADDR_MASK))&&(iom==IOM_SEL), go ADDR.
REQ-018 ADDR with sel=0 SHALL return IDLE next cycle, never driving ad_oe or strobes.
REQ-019 ADDR with rd_n=0, wr_n=1 SHALL pulse mem_re one cycle, go RD_WAIT.
REQ-020 ADDR with wr_n=0, rd_n=1 SHALL capture ad_i into mem_wdata, pulse mem_we one cycle, go WR_WAIT.
REQ-021 ADDR with rd_n=0 and wr_n=0 SHALL issue no strobe and remain ADDR.
REQ-022 RD_WAIT on mem_ack SHALL register mem_rdata into ad_o, go RD_DATA; WR_WAIT on mem_ack SHALL go END.
REQ-023 ad_oe SHALL equal (state==RD_DATA)&&!rd_n&&!den_n, combinational, so drive releases the cycle rd_n rises.
REQ-024 RD_DATA/END SHALL go IDLE on the first cycle rd_n=1 and wr_n=1.
REQ-025 rd_n or wr_n rising in RD_WAIT/WR_WAIT before mem_ack SHALL go DRAIN; DRAIN discards data and goes IDLE on mem_ack.
REQ-026 mem_ack outside RD_WAIT/WR_WAIT/DRAIN SHALL be ignored.
REQ-027 ad_o SHALL hold its value until next read capture.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, sel=0, mem_addr=0, mem_wdata=0, ad_o=0, mem_re=0, mem_we=0, ready=1, wait count 0.
REQ-029 Reset mid-access SHALL abandon the access; a subsequent mem_ack SHALL be ignored.

Configuration
REQ-030 With BUS_WAIT_STATE_EN defined, ready SHALL be low from the cycle after a strobe pulse until WAIT_CYCLES cycles after mem_ack (WAIT_CYCLES=0: ready rises the cycle after mem_ack).
REQ-031 Without BUS_WAIT_STATE_EN, ready SHALL be constant 1 and no wait counter SHALL exist.

Structure
REQ-032 Package bus8088_pkg SHALL hold the state enumeration and constants IOM_MEM=1'b0, IOM_IO=1'b1.
REQ-033 Address match SHALL live in sub-module bus_addr_decode (a, iom, parameters in; sel out); remaining logic in this module.

Verification
REQ-034 Read: ale with a=20'h01234, iom=0, then rd_n=0,den_n=0; mem_ack with mem_rdata=8'hA5 -> mem_re one pulse, mem_addr=20'h01234, ad_o=8'hA5, ad_oe=1 until rd_n=1.
REQ-035 Write: ale with a=20'h0FFFF, wr_n=0, ad_i=8'h3C -> mem_we one pulse, mem_wdata=8'h3C, no ad_oe.
REQ-036 Miss: ale with a=20'h10000 or iom=1 -> no strobe, ad_oe=0, IDLE after one cycle.
REQ-037 Abort: rd_n rises before mem_ack, ack three cycles later with 8'hFF -> ad_o unchanged, ad_oe never 1, IDLE after ack.
REQ-038 BUS_WAIT_STATE_EN, WAIT_CYCLES=2, ack two cycles after mem_re -> ready low exactly 4 cycles; without macro ready stays 1.
REQ-039 rst asserted in RD_WAIT, then mem_ack -> all outputs at reset values, no ad_o update.

Source files
------------

// File: rtl/bus8088_pkg.sv
// ============================================================================
// bus8088_pkg : shared state encoding and bus constants for the 8088 responder
// Rev 1.0
// ============================================================================
`default_nettype none

package bus8088_pkg;

  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_END     = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_addr_decode.sv
// ============================================================================
// bus_addr_decode : masked address / iom match for the 8088 responder
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_addr_decode
  import bus8088_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter logic [19:0] ADDR_MASK = 20'hF0000,
  parameter logic        IOM_SEL   = IOM_MEM
) (
  input  logic [19:0] a,
  input  logic        iom,
  output logic        sel
);

  assign sel = ((a & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && (iom == IOM_SEL);

endmodule

`default_nettype wire

// File: rtl/bus_responder_8088.sv
// ============================================================================
// bus_responder_8088 : 8088 bus slave bridging to a single-strobe backing store
// Rev 1.0 -- optional ready wait states via `BUS_WAIT_STATE_EN
// ============================================================================
`default_nettype none

module bus_responder_8088
  import bus8088_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter logic [19:0] ADDR_MASK   = 20'hF0000,
  parameter logic        IOM_SEL     = IOM_MEM,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] a,
  input  logic        ale,
  input  logic        iom,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        den_n,
  input  logic [7:0]  ad_i,
  output logic [7:0]  ad_o,
  output logic        ad_oe,
  output logic        ready,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  state_t state, state_next;
  logic   sel, sel_dec;
  logic   latch, re_set, we_set, rd_capture;

  bus_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK),
    .IOM_SEL   (IOM_SEL)
  ) u_decode (
    .a   (a),
    .iom (iom),
    .sel (sel_dec)
  );

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    re_set     = 1'b0;
    we_set     = 1'b0;
    rd_capture = 1'b0;
    case (state)
      ST_RD_WAIT: begin
        if (mem_ack) begin
          rd_capture = 1'b1;
          state_next = ST_RD_DATA;
        end else if (rd_n) begin
          state_next = ST_DRAIN;
        end
      end
      ST_WR_WAIT: begin
        if (mem_ack)   state_next = ST_END;
        else if (wr_n) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mem_ack) state_next = ST_IDLE;
      end
      default: begin
        // A new address phase preempts whatever the non-waiting state was doing.
        if (ale) begin
          latch      = 1'b1;
          state_next = ST_ADDR;
        end else if (state == ST_ADDR) begin
          if (!sel) begin
            state_next = ST_IDLE;
          end else if (!rd_n && wr_n) begin
            re_set     = 1'b1;
            state_next = ST_RD_WAIT;
          end else if (!wr_n && rd_n) begin
            we_set     = 1'b1;
            state_next = ST_WR_WAIT;
          end
        end else if (state == ST_RD_DATA || state == ST_END) begin
          if (rd_n && wr_n) state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= 1'b0;
      mem_addr  <= 20'h00000;
      mem_wdata <= 8'h00;
      ad_o      <= 8'h00;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state  <= state_next;
      mem_re <= re_set;
      mem_we <= we_set;
      if (latch) begin
        mem_addr <= a;
        sel      <= sel_dec;
      end
      if (we_set)     mem_wdata <= ad_i;
      if (rd_capture) ad_o      <= mem_rdata;
    end
  end

  assign ad_oe = (state == ST_RD_DATA) && !rd_n && !den_n;

`ifdef BUS_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic       ready_reg;
  logic [3:0] wait_cnt;
  logic       ack_in_access;

  assign ack_in_access = mem_ack &&
                         (state == ST_RD_WAIT || state == ST_WR_WAIT || state == ST_DRAIN);

  // ready drops after the strobe and rises WAIT_LOAD cycles past the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg <= 1'b1;
      wait_cnt  <= 4'd0;
    end else if (ack_in_access) begin
      if (WAIT_LOAD == 4'd0) ready_reg <= 1'b1;
      else                   wait_cnt  <= WAIT_LOAD;
    end else if (mem_re || mem_we) begin
      ready_reg <= 1'b0;
      wait_cnt  <= 4'd0;
    end else if (wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
      if (wait_cnt == 4'd1) ready_reg <= 1'b1;
    end
  end

  assign ready = ready_reg;
`else
  assign ready = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_responder_8088.sv
// ============================================================================
// tb_bus_responder_8088 : directed self-checking bench for bus_responder_8088
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_responder_8088;

`ifdef BUS_WAIT_STATE_EN
  localparam bit WS = 1'b1;
`else
  localparam bit WS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] a;
  logic        ale, iom, rd_n, wr_n, den_n;
  logic [7:0]  ad_i, ad_o, mem_wdata, mem_rdata;
  logic        ad_oe, ready, mem_re, mem_we, mem_ack;
  logic [19:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int oe_cnt = 0;

  bus_responder_8088 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .ale       (ale),
    .iom       (iom),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .den_n     (den_n),
    .ad_i      (ad_i),
    .ad_o      (ad_o),
    .ad_oe     (ad_oe),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) re_cnt++;
    if (mem_we) we_cnt++;
    if (ad_oe)  oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic addr_phase(input logic [19:0] addr, input logic io);
    a   = addr;
    iom = io;
    ale = 1'b1;
    step();
    ale = 1'b0;
  endtask

  task automatic release_bus();
    rd_n  = 1'b1;
    wr_n  = 1'b1;
    den_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_re"},    32'(mem_re), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_ad_o"},  32'(ad_o), 32'h0);
    check({tag, "_oe"},    32'(ad_oe), 32'd0);
  endtask

  initial begin
    rst = 1'b1; a = '0; ale = 1'b0; iom = 1'b0;
    rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1;
    ad_i = '0; mem_rdata = '0; mem_ack = 1'b0;
    step(2);
    rst = 1'b0;
    step();
    check_reset_state("rst");

    // Read with ack two cycles after the strobe
    addr_phase(20'h01234, 1'b0);
    check("rd_addr", 32'(mem_addr), 32'h01234);
    rd_n = 1'b0; den_n = 1'b0;
    step();                                   // strobe cycle
    check("rd_re_pulse", 32'(mem_re), 32'd1);
    check("rd_ready_k", 32'(ready), 32'd1);
    step();
    check("rd_re_once", 32'(mem_re), 32'd0);
    check("rd_ready_k1", 32'(ready), WS ? 32'd0 : 32'd1);
    check("rd_oe_wait", 32'(ad_oe), 32'd0);
    step();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    check("rd_ready_k2", 32'(ready), WS ? 32'd0 : 32'd1);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("rd_ad_o", 32'(ad_o), 32'hA5);
    check("rd_oe_on", 32'(ad_oe), 32'd1);
    check("rd_ready_k3", 32'(ready), WS ? 32'd0 : 32'd1);
    step();
    check("rd_ready_k4", 32'(ready), WS ? 32'd0 : 32'd1);
    check("rd_oe_hold", 32'(ad_oe), 32'd1);
    step();
    check("rd_ready_k5", 32'(ready), 32'd1);
    release_bus();
    #1;
    check("rd_oe_release", 32'(ad_oe), 32'd0);
    step();
    check("rd_re_count", 32'(re_cnt), 32'd1);
    check("rd_oe_count", 32'(oe_cnt), 32'd2);

    // Write
    addr_phase(20'h0FFFF, 1'b0);
    wr_n = 1'b0; ad_i = 8'h3C;
    step();
    check("wr_we_pulse", 32'(mem_we), 32'd1);
    check("wr_wdata", 32'(mem_wdata), 32'h3C);
    step();
    check("wr_we_once", 32'(mem_we), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    release_bus();
    step(4);
    check("wr_we_count", 32'(we_cnt), 32'd1);
    check("wr_no_oe", 32'(oe_cnt), 32'd2);
    check("wr_no_re", 32'(re_cnt), 32'd1);

    // Miss on address, then miss on iom
    addr_phase(20'h10000, 1'b0);
    check("miss_a_addr", 32'(mem_addr), 32'h10000);
    rd_n = 1'b0; den_n = 1'b0;
    step(3);
    check("miss_a_oe", 32'(ad_oe), 32'd0);
    release_bus();
    addr_phase(20'h01234, 1'b1);
    rd_n = 1'b0; den_n = 1'b0;
    step(3);
    check("miss_iom_oe", 32'(ad_oe), 32'd0);
    release_bus();
    iom = 1'b0;
    step();
    check("miss_no_re", 32'(re_cnt), 32'd1);
    check("miss_no_oe", 32'(oe_cnt), 32'd2);

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    check("idle_ack_ad_o", 32'(ad_o), 32'hA5);

    // Both strobes low: no strobe until wr_n returns high
    addr_phase(20'h00020, 1'b0);
    rd_n = 1'b0; wr_n = 1'b0; den_n = 1'b0;
    step(2);
    check("both_no_re", 32'(re_cnt), 32'd1);
    check("both_no_we", 32'(we_cnt), 32'd1);
    wr_n = 1'b1;
    step();
    check("both_then_re", 32'(mem_re), 32'd1);
    step();
    mem_ack = 1'b1; mem_rdata = 8'h42;
    step();
    mem_ack = 1'b0;
    check("both_ad_o", 32'(ad_o), 32'h42);
    check("both_oe", 32'(ad_oe), 32'd1);
    release_bus();
    step(4);

    // Abort: rd_n rises before ack, late ack with FF
    addr_phase(20'h00010, 1'b0);
    rd_n = 1'b0; den_n = 1'b0;
    step(2);
    release_bus();
    step(3);
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    step();
    mem_ack = 1'b0;
    check("abort_ad_o", 32'(ad_o), 32'h42);
    check("abort_re_count", 32'(re_cnt), 32'd3);
    oe_cnt = 0;
    step(4);
    // Back in IDLE: a fresh read must complete
    addr_phase(20'h00030, 1'b0);
    rd_n = 1'b0; den_n = 1'b0;
    step(2);
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    step();
    mem_ack = 1'b0;
    check("post_abort_ad_o", 32'(ad_o), 32'h5C);
    release_bus();
    step(4);

    // Reset in RD_WAIT, then a stray ack
    addr_phase(20'h02000, 1'b0);
    rd_n = 1'b0; den_n = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midrst");
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    step();
    mem_ack = 1'b0;
    check("midrst_ad_o", 32'(ad_o), 32'h0);
    check("midrst_oe", 32'(ad_oe), 32'd0);
    release_bus();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
